// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller.
// Holds the FSM encoding, the NOP instruction, the PC step and the control-bundle bit positions.
package pipeline_stall_ctrl_pkg;

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StStall = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

  // Control bundle layout: {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}
  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMREAD  = 6;
  localparam int unsigned CTRL_MEMWRITE = 5;
  localparam int unsigned CTRL_MEMTOREG = 4;
  localparam int unsigned CTRL_BRANCH   = 3;
  localparam int unsigned CTRL_ALUSRC   = 2;
  localparam int unsigned CTRL_ALUOP_HI = 1;
  localparam int unsigned CTRL_ALUOP_LO = 0;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle of hazard-unit inputs and pipeline-register outputs for the stall controller.
// The master side drives stall/flush/fetch data; the slave side is the controller.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned CTRL_W = 8
);
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   branch_target;
  logic [31:0]       instr_in;
  logic [CTRL_W-1:0] ctrl_in;

  logic [XLEN-1:0]   pc_out;
  logic [XLEN-1:0]   ifid_pc;
  logic [31:0]       ifid_instr;
  logic              ifid_valid;
  logic [CTRL_W-1:0] idex_ctrl;
  logic [1:0]        ctrl_state;
  logic [15:0]       stall_count;

  modport master (
    output stall, flush, branch_target, instr_in, ctrl_in,
    input  pc_out, ifid_pc, ifid_instr, ifid_valid, idex_ctrl, ctrl_state, stall_count
  );

  modport slave (
    input  stall, flush, branch_target, instr_in, ctrl_in,
    output pc_out, ifid_pc, ifid_instr, ifid_valid, idex_ctrl, ctrl_state, stall_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl_ifid_pipe_reg.sv
// IF/ID pipeline register with hold and clear.
// Clear wins over hold; a cleared stage holds a NOP bubble with PC 0.
module ifid_pipe_reg
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_hold,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic            o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Fetch PC, IF/ID and ID/EX control for a 5-stage pipeline with load-use stall and branch flush.
// Flush beats stall beats advance; every output is registered.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CTRL_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_stall_ctrl_if.slave  bus
);

  logic [XLEN-1:0]   r_pc;
  logic [CTRL_W-1:0] r_idex_ctrl;
  logic [1:0]        r_state;
  logic [15:0]       r_stall_count;

  logic              w_do_flush;
  logic              w_do_stall;
  logic [XLEN-1:0]   w_ifid_pc;
  logic [31:0]       w_ifid_instr;
  logic              w_ifid_valid;
  logic [XLEN-1:0]   w_pc_d;
  logic [CTRL_W-1:0] w_idex_d;
  logic [1:0]        w_state_d;
  logic [15:0]       w_stall_count_d;

  assign w_do_flush = bus.flush;
  assign w_do_stall = bus.stall & ~bus.flush;

  ifid_pipe_reg #(
    .XLEN (XLEN)
  ) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (w_do_stall),
    .i_clear (w_do_flush),
    .i_pc    (r_pc),
    .i_instr (bus.instr_in),
    .o_pc    (w_ifid_pc),
    .o_instr (w_ifid_instr),
    .o_valid (w_ifid_valid)
  );

  always_comb begin
    w_pc_d          = r_pc + XLEN'(PC_INC);
    w_idex_d        = w_ifid_valid ? bus.ctrl_in : '0;
    w_state_d       = StRun;
    w_stall_count_d = r_stall_count;
    if (w_do_flush) begin
      w_pc_d    = bus.branch_target;
      w_idex_d  = '0;
      w_state_d = StFlush;
    end else if (w_do_stall) begin
      w_pc_d    = r_pc;
      w_idex_d  = '0;
      w_state_d = StStall;
      if (r_stall_count != STALL_CNT_MAX) begin
        w_stall_count_d = r_stall_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_idex_ctrl   <= '0;
      r_state       <= StRun;
      r_stall_count <= '0;
    end else begin
      r_pc          <= w_pc_d;
      r_idex_ctrl   <= w_idex_d;
      r_state       <= w_state_d;
      r_stall_count <= w_stall_count_d;
    end
  end

  assign bus.pc_out      = r_pc;
  assign bus.ifid_pc     = w_ifid_pc;
  assign bus.ifid_instr  = w_ifid_instr;
  assign bus.ifid_valid  = w_ifid_valid;
  assign bus.idex_ctrl   = r_idex_ctrl;
  assign bus.ctrl_state  = r_state;
  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: reset, advance, stall, flush, wrap and saturation.
module tb_pipeline_stall_ctrl;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned CTRL_W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipeline_stall_ctrl_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  pipeline_stall_ctrl #(
    .XLEN     (XLEN),
    .RESET_PC ('0),
    .CTRL_W   (CTRL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic [63:0] tgt,
                       input logic [31:0] instr, input logic [7:0] ctrl);
    bus.stall         = st;
    bus.flush         = fl;
    bus.branch_target = tgt;
    bus.instr_in      = instr;
    bus.ctrl_in       = ctrl;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 64'h0, 32'h0050_0093, 8'h00);
    rst_n = 1'b0;
    #2;
    total++;
    if (bus.pc_out !== 64'h0 || bus.ifid_pc !== 64'h0 || bus.ifid_instr !== 32'h13 ||
        bus.ifid_valid !== 1'b0 || bus.idex_ctrl !== 8'h0 || bus.ctrl_state !== 2'd0 ||
        bus.stall_count !== 16'h0) begin
      bad++;
      $display("FAIL reset: pc=%h ifid_pc=%h instr=%h valid=%b idex=%h st=%0d cnt=%h",
               bus.pc_out, bus.ifid_pc, bus.ifid_instr, bus.ifid_valid, bus.idex_ctrl,
               bus.ctrl_state, bus.stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_advance();
    step();
    total++;
    if (bus.pc_out !== 64'h4 || bus.ifid_instr !== 32'h0050_0093 || bus.ifid_valid !== 1'b1 ||
        bus.idex_ctrl !== 8'h0 || bus.ifid_pc !== 64'h0 || bus.ctrl_state !== 2'd0) begin
      bad++;
      $display("FAIL first_advance: pc=%h instr=%h valid=%b idex=%h ifid_pc=%h st=%0d (want 4 00500093 1 00 0 0)",
               bus.pc_out, bus.ifid_instr, bus.ifid_valid, bus.idex_ctrl, bus.ifid_pc,
               bus.ctrl_state);
    end
  endtask

  task automatic test_advance_to_0x10();
    drive(1'b0, 1'b0, 64'h0, 32'h0010_0113, 8'h22);
    step();
    step();
    step();
    total++;
    if (bus.pc_out !== 64'h10 || bus.ifid_pc !== 64'hC || bus.idex_ctrl !== 8'h22) begin
      bad++;
      $display("FAIL advance: pc=%h ifid_pc=%h idex=%h (want 10 c 22)",
               bus.pc_out, bus.ifid_pc, bus.idex_ctrl);
    end
  endtask

  task automatic test_single_stall();
    drive(1'b1, 1'b0, 64'h0, 32'hDEAD_BEEF, 8'h83);
    step();
    total++;
    if (bus.pc_out !== 64'h10 || bus.idex_ctrl !== 8'h0 || bus.stall_count !== 16'd1 ||
        bus.ctrl_state !== 2'd1 || bus.ifid_pc !== 64'hC || bus.ifid_instr !== 32'h0010_0113) begin
      bad++;
      $display("FAIL stall: pc=%h idex=%h cnt=%0d st=%0d ifid_pc=%h instr=%h",
               bus.pc_out, bus.idex_ctrl, bus.stall_count, bus.ctrl_state, bus.ifid_pc,
               bus.ifid_instr);
    end
    drive(1'b0, 1'b0, 64'h0, 32'h0030_0193, 8'h83);
    step();
    total++;
    if (bus.pc_out !== 64'h14 || bus.idex_ctrl !== 8'h83 || bus.ctrl_state !== 2'd0 ||
        bus.stall_count !== 16'd1 || bus.ifid_pc !== 64'h10) begin
      bad++;
      $display("FAIL stall_release: pc=%h idex=%h st=%0d cnt=%0d ifid_pc=%h (want 14 83 0 1 10)",
               bus.pc_out, bus.idex_ctrl, bus.ctrl_state, bus.stall_count, bus.ifid_pc);
    end
  endtask

  task automatic test_flush_over_stall();
    drive(1'b1, 1'b1, 64'h200, 32'h1111_1111, 8'hFF);
    step();
    total++;
    if (bus.pc_out !== 64'h200 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h13 ||
        bus.ifid_pc !== 64'h0 || bus.idex_ctrl !== 8'h0 || bus.stall_count !== 16'd1 ||
        bus.ctrl_state !== 2'd2) begin
      bad++;
      $display("FAIL flush: pc=%h valid=%b instr=%h ifid_pc=%h idex=%h cnt=%0d st=%0d",
               bus.pc_out, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.idex_ctrl,
               bus.stall_count, bus.ctrl_state);
    end
    // A stall on the bubble must still hold, bubble and count.
    drive(1'b1, 1'b0, 64'h0, 32'h2222_2222, 8'hFF);
    step();
    total++;
    if (bus.pc_out !== 64'h200 || bus.ifid_valid !== 1'b0 || bus.idex_ctrl !== 8'h0 ||
        bus.stall_count !== 16'd2 || bus.ctrl_state !== 2'd1) begin
      bad++;
      $display("FAIL stall_on_bubble: pc=%h valid=%b idex=%h cnt=%0d st=%0d",
               bus.pc_out, bus.ifid_valid, bus.idex_ctrl, bus.stall_count, bus.ctrl_state);
    end
    drive(1'b0, 1'b0, 64'h0, 32'h3333_3333, 8'hFF);
    step();
    total++;
    if (bus.pc_out !== 64'h204 || bus.idex_ctrl !== 8'h0 || bus.ifid_valid !== 1'b1 ||
        bus.ifid_pc !== 64'h200 || bus.ifid_instr !== 32'h3333_3333) begin
      bad++;
      $display("FAIL post_flush_advance: pc=%h idex=%h valid=%b ifid_pc=%h instr=%h",
               bus.pc_out, bus.idex_ctrl, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr);
    end
    step();
    total++;
    if (bus.idex_ctrl !== 8'hFF || bus.pc_out !== 64'h208) begin
      bad++;
      $display("FAIL post_flush_ctrl: idex=%h pc=%h (want ff 208)", bus.idex_ctrl, bus.pc_out);
    end
  endtask

  task automatic test_pc_wrap();
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 8'h0);
    step();
    drive(1'b0, 1'b0, 64'h0, 32'h0000_0033, 8'h0);
    step();
    total++;
    if (bus.pc_out !== 64'h0 || bus.ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.ctrl_state !== 2'd0) begin
      bad++;
      $display("FAIL pc_wrap: pc=%h ifid_pc=%h st=%0d (want 0 fffffffffffffffc 0)",
               bus.pc_out, bus.ifid_pc, bus.ctrl_state);
    end
  endtask

  task automatic test_long_stall();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 64'h0, 32'h0050_0093, 8'h83);
    for (int i = 0; i < 65535; i++) step();
    total++;
    if (bus.stall_count !== 16'hFFFF || bus.pc_out !== 64'h0) begin
      bad++;
      $display("FAIL stall_reach_max: cnt=%h pc=%h (want ffff 0)", bus.stall_count, bus.pc_out);
    end
    for (int i = 0; i < 4465; i++) step();
    total++;
    if (bus.stall_count !== 16'hFFFF || bus.ctrl_state !== 2'd1 || bus.idex_ctrl !== 8'h0) begin
      bad++;
      $display("FAIL stall_saturate: cnt=%h st=%0d idex=%h (want ffff 1 0)",
               bus.stall_count, bus.ctrl_state, bus.idex_ctrl);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.pc_out !== 64'h0 || bus.ifid_pc !== 64'h0 || bus.ifid_instr !== 32'h13 ||
        bus.ifid_valid !== 1'b0 || bus.idex_ctrl !== 8'h0 || bus.ctrl_state !== 2'd0 ||
        bus.stall_count !== 16'h0) begin
      bad++;
      $display("FAIL async_reset_mid_stall: pc=%h instr=%h valid=%b idex=%h st=%0d cnt=%h",
               bus.pc_out, bus.ifid_instr, bus.ifid_valid, bus.idex_ctrl, bus.ctrl_state,
               bus.stall_count);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h0, 32'h0050_0093, 8'h83);
    rst_n = 1'b1;
    step();
    total++;
    if (bus.pc_out !== 64'h4 || bus.ifid_valid !== 1'b1 || bus.idex_ctrl !== 8'h0 ||
        bus.stall_count !== 16'h0 || bus.ctrl_state !== 2'd0) begin
      bad++;
      $display("FAIL after_reset_advance: pc=%h valid=%b idex=%h cnt=%h st=%0d",
               bus.pc_out, bus.ifid_valid, bus.idex_ctrl, bus.stall_count, bus.ctrl_state);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b0, 1'b1, 64'h400, 32'h0, 8'h0);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h400, 32'h0070_0393, 8'h0);
    rst_n = 1'b1;
    step();
    total++;
    if (bus.pc_out !== 64'h4 || bus.ifid_instr !== 32'h0070_0393 || bus.ctrl_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_flush: pc=%h instr=%h st=%0d (want 4 00700393 0)",
               bus.pc_out, bus.ifid_instr, bus.ctrl_state);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 32'h0, 8'h0);
    @(negedge clk);
    test_reset();
    test_first_advance();
    test_advance_to_0x10();
    test_single_stall();
    test_flush_over_stall();
    test_pc_wrap();
    test_long_stall();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter XLEN, default 64, PC and address width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 Parameter CTRL_W, default 8, control bundle width {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  load-use stall request from the hazard detection unit.
REQ-007 flush  in  1  taken branch resolved in EX; redirect fetch.
REQ-008 branch_target  in  XLEN  redirect PC, sampled when flush=1.
REQ-009 instr_in  in  32  instruction fetched from instruction memory at pc_out.
REQ-010 ctrl_in  in  CTRL_W  decoded control bundle for the instruction in IF/ID.
REQ-011 pc_out  out  XLEN  current fetch PC, driven to instruction memory.
REQ-012 ifid_pc  out  XLEN  registered PC of the instruction in IF/ID.
REQ-013 ifid_instr  out  32  registered instruction in IF/ID.
REQ-014 ifid_valid  out  1  IF/ID holds a real instruction, not a bubble.
REQ-015 idex_ctrl  out  CTRL_W  registered ID/EX control bundle; all-zero is a bubble.
REQ-016 ctrl_state  out  2  FSM state: RUN=0, STALL=1, FLUSH=2.
REQ-017 stall_count  out  16  saturating count of inserted load-use bubbles.

Function
REQ-018 Each cycle SHALL perform exactly one action. Flush has priority over stall, and stall has priority over advance.
REQ-019 Advance (flush=0, stall=0): pc_out<=pc_out+4; ifid_pc<=pc_out; ifid_instr<=instr_in; ifid_valid<=1; idex_ctrl<=ctrl_in when ifid_valid=1, else 0.
REQ-020 Stall (flush=0, stall=1): pc_out, ifid_pc, ifid_instr and ifid_valid SHALL hold their values; idex_ctrl<=0 (bubble).
REQ-021 Flush (flush=1, stall ignored): pc_out<=branch_target; ifid_instr<=NOP 0x00000013; ifid_valid<=0; ifid_pc<=0; idex_ctrl<=0.
REQ-022 PC increment SHALL wrap modulo 2^XLEN with no fault indication.
REQ-023 The FSM next state SHALL be FLUSH if flush=1, else STALL if stall=1, else RUN; the transition is legal from any state.
REQ-024 Consecutive stall cycles SHALL each hold the pipeline and each insert one bubble. There is no limit on stall length.
REQ-025 stall_count SHALL increment by 1 on every cycle taking the stall action, saturate at 0xFFFF, and not increment on flush cycles.
REQ-026 Stall and advance SHALL have latency 1 cycle from input sample to registered output; there is no combinational path from stall or flush to any output.
REQ-027 stall with ifid_valid=0 SHALL still hold and bubble, and SHALL be counted.

Reset
REQ-028 While rst_n=0, outputs SHALL immediately be: pc_out=RESET_PC, ifid_pc=0, ifid_instr=0x00000013, ifid_valid=0, idex_ctrl=0, ctrl_state=RUN, stall_count=0.
REQ-029 Reset asserted mid-stall or mid-flush SHALL abandon the operation; the first edge after release SHALL perform a normal action from RESET_PC.

Structure
REQ-030 A shared package SHALL hold the state encoding (RUN/STALL/FLUSH), the NOP constant, the PC increment constant 4 and the control-bundle bit positions.
REQ-031 The IF/ID register (pc, instr, valid with hold and clear inputs) SHALL be one sub-module named ifid_pipe_reg; the PC, ID/EX control, FSM and counter live in the top module.

Verification
REQ-032 Reset release with stall=flush=0 and instr_in=0x00500093: after 1 edge pc_out=4, ifid_instr=0x00500093, ifid_valid=1, idex_ctrl=0.
REQ-033 Single stall at pc_out=0x10 with ctrl_in=0x83: pc_out stays 0x10 for 1 cycle, idex_ctrl=0, stall_count=1, ctrl_state=STALL; the next cycle advances and idex_ctrl=0x83.
REQ-034 flush=1 and stall=1 with branch_target=0x200: pc_out=0x200, ifid_valid=0, ifid_instr=0x00000013, stall_count unchanged, ctrl_state=FLUSH.
REQ-035 pc_out=2^64-4 advancing: next pc_out=0.
REQ-036 stall held for 70000 cycles: stall_count=0xFFFF with no wrap; rst_n pulsed low mid-stall gives all reset values asynchronously.
